truth_table_engine: RTL and testbench

TRUTH_TABLE_ENGINE -- requirements
Module: truth_table_engine

---
 rtl/truth_table_engine.sv | 118 +++++++++++
 tb/tb_truth_table_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_engine.sv
// Programmable 2^IN_W x OUT_W truth table with eval and sweep readout.
// Optional macro TTE_PARITY_EN adds a registered res_par output.
module truth_table_engine #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_we,
  input  logic [IN_W-1:0]  prog_addr,
  input  logic [OUT_W-1:0] prog_data,
  input  logic             eval_valid,
  input  logic [IN_W-1:0]  eval_in,
  output logic             eval_ready,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IN_W-1:0]  res_addr,
`ifdef TTE_PARITY_EN
  output logic [OUT_W-1:0] res_data,
  output logic             res_par
`else
  output logic [OUT_W-1:0] res_data
`endif
);

  localparam int ROWS = 1 << IN_W;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state;
  state_t           state_nx;
  logic [IN_W:0]    cnt;
  logic [IN_W:0]    cnt_nx;
  logic [OUT_W-1:0] tbl [ROWS];

  logic             slot_free;
  logic             eval_fire;
  logic             sweep_load;
  logic             last_take;
  logic             load;
  logic [IN_W-1:0]  ld_addr;
  logic [OUT_W-1:0] ld_data;

  assign sweep_busy = (state == SWEEP);

  always_comb begin
    slot_free  = !res_valid || res_ready;
    eval_ready = rst_n && (state == IDLE)
                 && !sweep_start && slot_free;
    eval_fire  = eval_valid && eval_ready;
    sweep_load = (state == SWEEP) && slot_free
                 && !cnt[IN_W];
    // counter parked at ROWS means the held row is the last one
    last_take  = (state == SWEEP) && cnt[IN_W]
                 && res_valid && res_ready;
    load       = eval_fire || sweep_load;
    ld_addr    = eval_in;
    unique case (1'b1)
      sweep_load: ld_addr = cnt[IN_W-1:0];
      default:    ld_addr = eval_in;
    endcase
    ld_data    = tbl[ld_addr];
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (sweep_start) begin
          state_nx = SWEEP;
          cnt_nx   = '0;
        end
      end
      SWEEP: begin
        if (sweep_load) cnt_nx = cnt + 1'b1;
        if (last_take)  state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      res_valid  <= 1'b0;
      res_addr   <= '0;
      res_data   <= '0;
      sweep_done <= 1'b0;
      for (int i = 0; i < ROWS; i++) tbl[i] <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      sweep_done <= last_take;
      // read of ld_data sees the old row, so eval is read-before-write
      if (prog_we && state == IDLE) tbl[prog_addr] <= prog_data;
      if (load) begin
        res_valid <= 1'b1;
        res_addr  <= ld_addr;
        res_data  <= ld_data;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef TTE_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)    res_par <= 1'b0;
    else if (load) res_par <= ^ld_data;
  end
`endif

endmodule

// File: tb/tb_truth_table_engine.sv
// Self-checking bench for truth_table_engine: vector table plus
// scoreboard queue of expected results and sweep corner sequences.
module tb_truth_table_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [4:0] prog_data;
  logic       eval_valid;
  logic [3:0] eval_in;
  logic       eval_ready;
  logic       sweep_start;
  logic       sweep_busy;
  logic       sweep_done;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_addr;
  logic [4:0] res_data;
`ifdef TTE_PARITY_EN
  logic       res_par;
`endif

  always #5 clk = ~clk;

  truth_table_engine #(.IN_W(4), .OUT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .eval_valid  (eval_valid),
    .eval_in     (eval_in),
    .eval_ready  (eval_ready),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_addr    (res_addr),
`ifdef TTE_PARITY_EN
    .res_data    (res_data),
    .res_par     (res_par)
`else
    .res_data    (res_data)
`endif
  );

  typedef struct packed {
    logic [3:0] a;
    logic [4:0] d;
  } vec_t;

  vec_t       vecs [16];
  vec_t       q [$];
  logic [4:0] model [16];
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  bit         in_sweep = 0;
  bit         seen;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    vec_t e;
    if (rst_n && res_valid && res_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("sb_addr", 32'(res_addr), 32'(e.a));
        chk("sb_data", 32'(res_data), 32'(e.d));
      end
    end
    if (sweep_done) done_cnt++;
  end

  task automatic step();
    @(negedge clk);
    if (rst_n && eval_valid && eval_ready)
      q.push_back(vec_t'{a: eval_in, d: model[eval_in]});
    if (rst_n && prog_we && !in_sweep)
      model[prog_addr] = prog_data;
    if (rst_n && sweep_start && !in_sweep) begin
      for (int i = 0; i < 16; i++)
        q.push_back(vec_t'{a: 4'(i), d: model[i]});
      in_sweep = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input bit toggle);
    done_cnt = 0;
    res_ready = 1'b1;
    sweep_start = 1'b1;
    eval_valid = 1'b1;
    eval_in = 4'd2;
    #1;
    chk("eval_ready_vs_start", 32'(eval_ready), 32'd0);
    step();
    sweep_start = 1'b0;
    eval_valid = 1'b0;
    chk("busy_after_start", 32'(sweep_busy), 32'd1);
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      res_ready = toggle ? ~c[0] : 1'b1;
      sweep_start = (c == 5);
      step();
      sweep_start = 1'b0;
      if (sweep_done) seen = 1;
    end
    chk("sweep_done_seen", 32'(seen), 32'd1);
    chk("busy_clear_at_done", 32'(sweep_busy), 32'd0);
    chk("sweep_rows_left", 32'(q.size()), 32'd0);
    in_sweep = 0;
    res_ready = 1'b1;
    step();
    chk("done_one_cycle", 32'(sweep_done), 32'd0);
    chk("done_count", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{a: 4'd0,  d: 5'h01};
    vecs[1]  = '{a: 4'd1,  d: 5'h12};
    vecs[2]  = '{a: 4'd2,  d: 5'h0A};
    vecs[3]  = '{a: 4'd3,  d: 5'h05};
    vecs[4]  = '{a: 4'd4,  d: 5'h1C};
    vecs[5]  = '{a: 4'd5,  d: 5'h07};
    vecs[6]  = '{a: 4'd6,  d: 5'h10};
    vecs[7]  = '{a: 4'd7,  d: 5'h03};
    vecs[8]  = '{a: 4'd8,  d: 5'h19};
    vecs[9]  = '{a: 4'd9,  d: 5'h0E};
    vecs[10] = '{a: 4'd10, d: 5'h15};
    vecs[11] = '{a: 4'd11, d: 5'h08};
    vecs[12] = '{a: 4'd12, d: 5'h16};
    vecs[13] = '{a: 4'd13, d: 5'h0B};
    vecs[14] = '{a: 4'd14, d: 5'h04};
    vecs[15] = '{a: 4'd15, d: 5'h1F};
    for (int i = 0; i < 16; i++) model[i] = '0;

    rst_n = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    eval_valid = 1'b1;
    eval_in = 4'd3;
    sweep_start = 1'b0;
    res_ready = 1'b1;
    step();
    step();
    chk("rst_eval_ready", 32'(eval_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_addr", 32'(res_addr), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_busy", 32'(sweep_busy), 32'd0);
    chk("rst_done", 32'(sweep_done), 32'd0);
    eval_valid = 1'b0;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1;
      prog_addr = vecs[i].a;
      prog_data = vecs[i].d;
      step();
    end
    prog_we = 1'b0;

    for (int i = 0; i < 16; i++) begin
      eval_valid = 1'b1;
      eval_in = vecs[i].a;
      step();
      chk("lat1_valid", 32'(res_valid), 32'd1);
      chk("lat1_addr", 32'(res_addr), 32'(vecs[i].a));
      chk("lat1_data", 32'(res_data), 32'(vecs[i].d));
    end
    eval_valid = 1'b0;
    step();

    res_ready = 1'b0;
    eval_valid = 1'b1;
    eval_in = 4'd3;
    step();
    eval_in = 4'd7;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_addr", 32'(res_addr), 32'd3);
      chk("hold_data", 32'(res_data), 32'(vecs[3].d));
      chk("hold_eval_ready", 32'(eval_ready), 32'd0);
    end
    res_ready = 1'b1;
    #1;
    chk("release_eval_ready", 32'(eval_ready), 32'd1);
    step();
    chk("release_addr", 32'(res_addr), 32'd7);
    eval_valid = 1'b0;
    step();

    run_sweep(1'b0);
    run_sweep(1'b1);

    prog_we = 1'b1;
    prog_addr = 4'd5;
    prog_data = 5'h03;
    step();
    prog_data = 5'h1F;
    eval_valid = 1'b1;
    eval_in = 4'd5;
    step();
    chk("rbw_old", 32'(res_data), 32'h03);
    prog_we = 1'b0;
    step();
    chk("rbw_new", 32'(res_data), 32'h1F);
    eval_valid = 1'b0;
    step();

`ifdef TTE_PARITY_EN
    prog_we = 1'b1;
    prog_addr = 4'd9;
    prog_data = 5'h13;
    step();
    prog_addr = 4'd10;
    prog_data = 5'h11;
    step();
    prog_we = 1'b0;
    eval_valid = 1'b1;
    eval_in = 4'd9;
    step();
    chk("par_13", 32'(res_par), 32'd1);
    eval_in = 4'd10;
    step();
    chk("par_11", 32'(res_par), 32'd0);
    eval_valid = 1'b0;
    step();
`endif

    done_cnt = 0;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (res_valid && res_addr == 4'd7) seen = 1;
      else step();
    end
    chk("reached_row7", 32'(seen), 32'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_busy", 32'(sweep_busy), 32'd0);
    chk("mid_rst_done", 32'(sweep_done), 32'd0);
    q.delete();
    in_sweep = 0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      eval_valid = 1'b1;
      eval_in = 4'(15 - i);
      step();
      chk("post_rst_data", 32'(res_data), 32'd0);
    end
    eval_valid = 1'b0;
    step();
    step();
    chk("no_done_after_rst", 32'(done_cnt), 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
